i2c_slave_controller: RTL and testbench

Protocol-sequencing FSM for the I2C target (slave) side of the I2C peripheral; the counterpart of the master controller. It consumes SCL/SDA event strobes from the bus edge detectors and an address-compare result. It drives the shared shift register, the RX/TX FIFO strobes, the SDA output mux and the SCL stretch hold. It supports 7-bit addressing, master-write and master-read transfers, repeated START, and clock stretching on FIFO full/empty.

---
 rtl/i2c_slave_controller.sv | 275 +++++++++++++++++++++++++++
 tb/tb_i2c_slave_controller.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_controller.sv
// ---------------------------------------------------------------------------
// i2c_slave_controller
//
// Protocol-sequencing FSM for the target (slave) side of the I2C peripheral.
// It consumes synchronized SCL/SDA event strobes and an address-compare
// result. It steers the shared shift register, the RX/TX FIFO strobes, the
// SDA output mux and the SCL stretch hold. It handles 7-bit addressing,
// master-write and master-read transfers, repeated START, and clock
// stretching when the RX FIFO is full or the TX FIFO is empty.
//
// Strobe semantics: every *_found / scl_* input is a one-clock pulse. Every
// set_* output and rx_fifo_enable is a registered one-clock pulse. The
// shift_rx_enable and shift_tx_enable outputs are combinational: each one is
// the incoming SCL edge strobe, qualified by the current state.
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   enable                      slave mode enable (0 forces IDLE)
//   start_found, stop_found     START/repeated START and STOP strobes
//   scl_rising, scl_falling     synchronized SCL edge strobes
//   sda_in                      synchronized SDA level
//   address_match, rw_bit       address compare result / R/W bit of addr byte
//   rx_fifo_full, tx_fifo_empty FIFO status
//   stretch_enabled             clock stretching permitted
//   shift_rx_enable             shift SDA into shift register
//   shift_tx_enable             advance shift register MSB-out
//   shift_load                  load shift register from TX FIFO head
//   sda_mode                    0 release, 1 drive ACK low, 2 drive shift MSB
//   scl_hold                    hold SCL low
//   rx_fifo_enable              push shift register to RX FIFO
//   tx_fifo_enable              pop TX FIFO
//   set_address_hit             pulse: this target was addressed
//   set_nack_sent               pulse: byte NACKed because RX FIFO overflowed
//   set_transaction_complete    pulse: addressed transaction ended by STOP
//   busy                        addressed and transaction in progress
//   fsm_state                   current FSM state (debug observation)
// ---------------------------------------------------------------------------
module i2c_slave_controller #(
  parameter int BIT_CNT_W = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       scl_rising,
  input  logic       scl_falling,
  input  logic       sda_in,
  input  logic       address_match,
  input  logic       rw_bit,
  input  logic       rx_fifo_full,
  input  logic       tx_fifo_empty,
  input  logic       stretch_enabled,
  output logic       shift_rx_enable,
  output logic       shift_tx_enable,
  output logic       shift_load,
  output logic [1:0] sda_mode,
  output logic       scl_hold,
  output logic       rx_fifo_enable,
  output logic       tx_fifo_enable,
  output logic       set_address_hit,
  output logic       set_nack_sent,
  output logic       set_transaction_complete,
  output logic       busy,
  output logic [3:0] fsm_state
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ADDR_RX    = 4'd1;
  localparam logic [3:0] S_ADDR_CHK   = 4'd2;
  localparam logic [3:0] S_ACK_WAIT   = 4'd3;
  localparam logic [3:0] S_ACK_DRIVE  = 4'd4;
  localparam logic [3:0] S_RX_BYTE    = 4'd5;
  localparam logic [3:0] S_RX_SAVE    = 4'd6;
  localparam logic [3:0] S_TX_STRETCH = 4'd7;
  localparam logic [3:0] S_TX_LOAD    = 4'd8;
  localparam logic [3:0] S_TX_BYTE    = 4'd9;
  localparam logic [3:0] S_TX_ACK     = 4'd10;
  localparam logic [3:0] S_WAIT_STOP  = 4'd11;

  localparam logic [BIT_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [BIT_CNT_W-1:0] CNT_ONE  = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] CNT_MAX  = BIT_CNT_W'(8);

  logic [3:0]           state, state_n;
  logic [BIT_CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic                 addressed, addressed_n;
  logic                 dir, dir_n;
  logic                 nack_pending, nack_pending_n;
  // RX_SAVE saw SCL fall while stalled, so the ACK slot is already open.
  logic                 hold_armed, hold_armed_n;
  // TX_ACK sampled an ACK on the rising edge of the ninth clock.
  logic                 ack_seen, ack_seen_n;
  // TX_LOAD was entered with no data: load 0xFF without popping.
  logic                 no_pop, no_pop_n;
  logic                 hit_n, nack_sent_n, complete_n, rx_push_n;
  logic                 fall_seen;
  logic                 normal_step;

  // The counter saturates at 8, so it can never wrap.
  assign cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign fall_seen   = hold_armed | scl_falling;
  // START/STOP and disable take priority over any SCL edge that arrives in
  // the same cycle, so the shift pulses are suppressed then as well.
  assign normal_step = enable & ~stop_found & ~start_found;

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    addressed_n    = addressed;
    dir_n          = dir;
    nack_pending_n = nack_pending;
    hold_armed_n   = hold_armed;
    ack_seen_n     = ack_seen;
    no_pop_n       = no_pop;
    hit_n          = 1'b0;
    nack_sent_n    = 1'b0;
    complete_n     = 1'b0;
    rx_push_n      = 1'b0;

    if (!enable) begin
      state_n        = S_IDLE;
      cnt_n          = CNT_ZERO;
      addressed_n    = 1'b0;
      nack_pending_n = 1'b0;
      hold_armed_n   = 1'b0;
      ack_seen_n     = 1'b0;
      no_pop_n       = 1'b0;
    end else if (stop_found) begin
      state_n        = S_IDLE;
      cnt_n          = CNT_ZERO;
      complete_n     = addressed;
      addressed_n    = 1'b0;
      nack_pending_n = 1'b0;
      hold_armed_n   = 1'b0;
      ack_seen_n     = 1'b0;
      no_pop_n       = 1'b0;
    end else if (start_found) begin
      // A repeated START keeps the addressed flag: the transaction goes on.
      state_n        = S_ADDR_RX;
      cnt_n          = CNT_ZERO;
      nack_pending_n = 1'b0;
      hold_armed_n   = 1'b0;
      ack_seen_n     = 1'b0;
      no_pop_n       = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_ADDR_RX: begin
          if (scl_rising) begin
            cnt_n = cnt_inc;
            if (cnt == CNT_LAST) state_n = S_ADDR_CHK;
          end
        end
        S_ADDR_CHK: begin
          if (address_match) begin
            state_n     = S_ACK_WAIT;
            addressed_n = 1'b1;
            hit_n       = 1'b1;
            dir_n       = rw_bit;
          end else begin
            state_n = S_WAIT_STOP;
          end
        end
        S_ACK_WAIT: begin
          if (scl_falling) state_n = nack_pending ? S_WAIT_STOP : S_ACK_DRIVE;
        end
        S_ACK_DRIVE: begin
          if (scl_falling) begin
            cnt_n   = CNT_ZERO;
            state_n = dir ? S_TX_STRETCH : S_RX_BYTE;
          end
        end
        S_RX_BYTE: begin
          hold_armed_n = 1'b0;
          if (scl_rising) begin
            cnt_n = cnt_inc;
            if (cnt == CNT_LAST) state_n = S_RX_SAVE;
          end
        end
        S_RX_SAVE: begin
          if (scl_falling) hold_armed_n = 1'b1;
          // If SCL already fell while the FIFO stalled us, the ACK slot is
          // open. Drive ACK (or release for a NACK) at once, rather than
          // waiting for a falling edge that has already happened.
          if (!rx_fifo_full) begin
            rx_push_n    = 1'b1;
            hold_armed_n = 1'b0;
            state_n      = fall_seen ? S_ACK_DRIVE : S_ACK_WAIT;
          end else if (!stretch_enabled) begin
            nack_pending_n = 1'b1;
            nack_sent_n    = 1'b1;
            hold_armed_n   = 1'b0;
            state_n        = fall_seen ? S_WAIT_STOP : S_ACK_WAIT;
          end
        end
        S_TX_STRETCH: begin
          if (!(tx_fifo_empty && stretch_enabled)) begin
            state_n  = S_TX_LOAD;
            no_pop_n = tx_fifo_empty;
          end
        end
        S_TX_LOAD: begin
          state_n  = S_TX_BYTE;
          no_pop_n = 1'b0;
        end
        S_TX_BYTE: begin
          ack_seen_n = 1'b0;
          if (scl_falling) begin
            cnt_n = cnt_inc;
            if (cnt == CNT_LAST) state_n = S_TX_ACK;
          end
        end
        S_TX_ACK: begin
          if (scl_rising) begin
            if (sda_in) state_n = S_WAIT_STOP;
            else        ack_seen_n = 1'b1;
          end else if (scl_falling && ack_seen) begin
            state_n    = S_TX_STRETCH;
            cnt_n      = CNT_ZERO;
            ack_seen_n = 1'b0;
          end
        end
        S_WAIT_STOP: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                    <= S_IDLE;
      cnt                      <= CNT_ZERO;
      addressed                <= 1'b0;
      dir                      <= 1'b0;
      nack_pending             <= 1'b0;
      hold_armed               <= 1'b0;
      ack_seen                 <= 1'b0;
      no_pop                   <= 1'b0;
      set_address_hit          <= 1'b0;
      set_nack_sent            <= 1'b0;
      set_transaction_complete <= 1'b0;
      rx_fifo_enable           <= 1'b0;
    end else begin
      state                    <= state_n;
      cnt                      <= cnt_n;
      addressed                <= addressed_n;
      dir                      <= dir_n;
      nack_pending             <= nack_pending_n;
      hold_armed               <= hold_armed_n;
      ack_seen                 <= ack_seen_n;
      no_pop                   <= no_pop_n;
      set_address_hit          <= hit_n;
      set_nack_sent            <= nack_sent_n;
      set_transaction_complete <= complete_n;
      rx_fifo_enable           <= rx_push_n;
    end
  end

  assign shift_rx_enable = normal_step & scl_rising &
                           ((state == S_ADDR_RX) | (state == S_RX_BYTE));
  assign shift_tx_enable = normal_step & scl_falling & (state == S_TX_BYTE);
  assign shift_load      = (state == S_TX_LOAD);
  assign tx_fifo_enable  = (state == S_TX_LOAD) & ~no_pop;
  assign sda_mode        = (state == S_ACK_DRIVE) ? 2'd1 :
                           ((state == S_TX_LOAD) | (state == S_TX_BYTE)) ? 2'd2 :
                           2'd0;
  assign scl_hold        = (state == S_TX_LOAD) |
                           ((state == S_TX_STRETCH) & tx_fifo_empty & stretch_enabled) |
                           ((state == S_RX_SAVE) & hold_armed);
  assign busy            = addressed & (state != S_IDLE);
  assign fsm_state       = state;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_controller
//
// Directed bench for i2c_slave_controller. Bus activity is modelled at the
// strobe level: each SCL bit is a rising strobe followed by a falling
// strobe, and one bit period is 10 clocks. The own address is 7'h42.
// Inputs change on the negative clock edge, and outputs are sampled on the
// negative edge or by pulse counters on the positive edge.
// ---------------------------------------------------------------------------
module tb_i2c_slave_controller;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_ADDR_RX    = 4'd1;
  localparam logic [3:0] ST_ACK_WAIT   = 4'd3;
  localparam logic [3:0] ST_ACK_DRIVE  = 4'd4;
  localparam logic [3:0] ST_RX_BYTE    = 4'd5;
  localparam logic [3:0] ST_RX_SAVE    = 4'd6;
  localparam logic [3:0] ST_TX_STRETCH = 4'd7;
  localparam logic [3:0] ST_TX_LOAD    = 4'd8;
  localparam logic [3:0] ST_TX_BYTE    = 4'd9;
  localparam logic [3:0] ST_WAIT_STOP  = 4'd11;
  localparam logic [6:0] OWN_ADDR      = 7'h42;
  localparam int         BIT_CYCLES    = 10;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       enable = 1'b0;
  logic       start_found = 1'b0;
  logic       stop_found = 1'b0;
  logic       scl_rising = 1'b0;
  logic       scl_falling = 1'b0;
  logic       sda_in = 1'b1;
  logic       address_match = 1'b0;
  logic       rw_bit = 1'b0;
  logic       rx_fifo_full = 1'b0;
  logic       tx_fifo_empty = 1'b0;
  logic       stretch_enabled = 1'b1;
  logic       shift_rx_enable, shift_tx_enable, shift_load, scl_hold;
  logic [1:0] sda_mode;
  logic       rx_fifo_enable, tx_fifo_enable;
  logic       set_address_hit, set_nack_sent, set_transaction_complete, busy;
  logic [3:0] fsm_state;
  logic [11:0] outs;

  int checks = 0;
  int failures = 0;

  // Pulse and level counters, plus a snapshot of them taken at test start.
  int n_srx = 0, n_stx = 0, n_load = 0, n_push = 0, n_pop = 0;
  int n_hit = 0, n_nack = 0, n_done = 0, n_ack = 0, n_drive = 0;
  int s_srx, s_stx, s_load, s_push, s_pop, s_hit, s_nack, s_done, s_ack, s_drive;

  i2c_slave_controller #(.BIT_CNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .start_found(start_found), .stop_found(stop_found),
    .scl_rising(scl_rising), .scl_falling(scl_falling), .sda_in(sda_in),
    .address_match(address_match), .rw_bit(rw_bit),
    .rx_fifo_full(rx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .stretch_enabled(stretch_enabled),
    .shift_rx_enable(shift_rx_enable), .shift_tx_enable(shift_tx_enable),
    .shift_load(shift_load), .sda_mode(sda_mode), .scl_hold(scl_hold),
    .rx_fifo_enable(rx_fifo_enable), .tx_fifo_enable(tx_fifo_enable),
    .set_address_hit(set_address_hit), .set_nack_sent(set_nack_sent),
    .set_transaction_complete(set_transaction_complete), .busy(busy),
    .fsm_state(fsm_state)
  );

  assign outs = {shift_rx_enable, shift_tx_enable, shift_load, sda_mode, scl_hold,
                 rx_fifo_enable, tx_fifo_enable, set_address_hit, set_nack_sent,
                 set_transaction_complete, busy};

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- pulse counters ----
  always @(posedge clk) begin
    if (shift_rx_enable)          n_srx   <= n_srx + 1;
    if (shift_tx_enable)          n_stx   <= n_stx + 1;
    if (shift_load)               n_load  <= n_load + 1;
    if (rx_fifo_enable)           n_push  <= n_push + 1;
    if (tx_fifo_enable)           n_pop   <= n_pop + 1;
    if (set_address_hit)          n_hit   <= n_hit + 1;
    if (set_nack_sent)            n_nack  <= n_nack + 1;
    if (set_transaction_complete) n_done  <= n_done + 1;
    if (sda_mode == 2'd1)         n_ack   <= n_ack + 1;
    if (sda_mode != 2'd0)         n_drive <= n_drive + 1;
  end

  // ---- driver tasks ----
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_srx = n_srx; s_stx = n_stx; s_load = n_load; s_push = n_push; s_pop = n_pop;
    s_hit = n_hit; s_nack = n_nack; s_done = n_done; s_ack = n_ack; s_drive = n_drive;
  endtask

  task automatic do_start();
    @(negedge clk); start_found = 1'b1;
    @(negedge clk); start_found = 1'b0;
    tick(3);
  endtask

  task automatic do_stop();
    @(negedge clk); stop_found = 1'b1;
    @(negedge clk); stop_found = 1'b0;
    tick(3);
  endtask

  task automatic scl_rise(input logic b);
    @(negedge clk); sda_in = b; scl_rising = 1'b1;
    @(negedge clk); scl_rising = 1'b0;
    tick(3);
  endtask

  task automatic scl_fall();
    @(negedge clk); scl_falling = 1'b1;
    @(negedge clk); scl_falling = 1'b0;
    tick(3);
  endtask

  task automatic send_bit(input logic b);
    scl_rise(b);
    scl_fall();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  // The address comparator is modelled here: match on byte[7:1] == own address.
  task automatic send_addr(input logic [7:0] b);
    address_match = (b[7:1] == OWN_ADDR);
    rw_bit        = b[0];
    send_bits(b, 8);
  endtask

  // ---- tests ----
  task automatic test_reset();
    n_rst = 1'b0;
    tick(3);
    checks++;
    if (outs !== 12'd0) begin failures++; $display("FAIL reset_outs: got %h expected 000", outs); end
    checks++;
    if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
    n_rst = 1'b1; enable = 1'b1;
    tick(3);
    checks++;
    if (outs !== 12'd0 || fsm_state !== ST_IDLE) begin
      failures++; $display("FAIL idle_after_reset: outs %h state %0d expected 000/0", outs, fsm_state);
    end
  endtask

  task automatic test_write();
    snap();
    do_start();
    send_addr({OWN_ADDR, 1'b0});
    checks++;
    if (n_hit - s_hit !== 1) begin failures++; $display("FAIL wr_addr_hit: got %0d expected 1", n_hit - s_hit); end
    checks++;
    if (fsm_state !== ST_ACK_DRIVE || sda_mode !== 2'd1) begin
      failures++; $display("FAIL wr_ack_drive: state %0d sda_mode %0d expected %0d/1", fsm_state, sda_mode, ST_ACK_DRIVE);
    end
    send_bit(1'b0);
    checks++;
    if (n_ack - s_ack !== BIT_CYCLES) begin failures++; $display("FAIL wr_ack_len: got %0d expected %0d", n_ack - s_ack, BIT_CYCLES); end
    checks++;
    if (fsm_state !== ST_RX_BYTE) begin failures++; $display("FAIL wr_rx_byte: got %0d expected %0d", fsm_state, ST_RX_BYTE); end
    send_bits(8'hA5, 8);
    send_bit(1'b0);
    checks++;
    if (n_push - s_push !== 1) begin failures++; $display("FAIL wr_push: got %0d expected 1", n_push - s_push); end
    checks++;
    if (n_srx - s_srx !== 16) begin failures++; $display("FAIL wr_shift_rx: got %0d expected 16", n_srx - s_srx); end
    checks++;
    if (n_ack - s_ack !== 2 * BIT_CYCLES) begin failures++; $display("FAIL wr_ack_total: got %0d expected %0d", n_ack - s_ack, 2 * BIT_CYCLES); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy: got %0d expected 1", busy); end
    do_stop();
    checks++;
    if (n_done - s_done !== 1) begin failures++; $display("FAIL wr_complete: got %0d expected 1", n_done - s_done); end
    checks++;
    if (fsm_state !== ST_IDLE || busy !== 1'b0) begin
      failures++; $display("FAIL wr_idle: state %0d busy %0d expected 0/0", fsm_state, busy);
    end
  endtask

  task automatic test_mismatch();
    snap();
    do_start();
    send_addr({7'h43, 1'b0});
    send_bit(1'b0);
    checks++;
    if (fsm_state !== ST_WAIT_STOP) begin failures++; $display("FAIL mm_state: got %0d expected %0d", fsm_state, ST_WAIT_STOP); end
    checks++;
    if (n_drive - s_drive !== 0) begin failures++; $display("FAIL mm_sda_driven: got %0d cycles expected 0", n_drive - s_drive); end
    checks++;
    if (n_hit - s_hit !== 0 || n_push - s_push !== 0 || n_pop - s_pop !== 0) begin
      failures++; $display("FAIL mm_strobes: hit %0d push %0d pop %0d expected 0/0/0", n_hit - s_hit, n_push - s_push, n_pop - s_pop);
    end
    do_stop();
    checks++;
    if (n_done - s_done !== 0) begin failures++; $display("FAIL mm_complete: got %0d expected 0", n_done - s_done); end
  endtask

  task automatic test_read();
    snap();
    tx_fifo_empty = 1'b0;
    do_start();
    send_addr({OWN_ADDR, 1'b1});
    send_bit(1'b0);
    checks++;
    if (fsm_state !== ST_TX_BYTE || sda_mode !== 2'd2) begin
      failures++; $display("FAIL rd_tx_byte: state %0d sda_mode %0d expected %0d/2", fsm_state, sda_mode, ST_TX_BYTE);
    end
    send_bits(8'h00, 8);
    send_bit(1'b0);
    send_bits(8'h00, 8);
    send_bit(1'b1);
    checks++;
    if (n_pop - s_pop !== 2 || n_load - s_load !== 2) begin
      failures++; $display("FAIL rd_pops: pop %0d load %0d expected 2/2", n_pop - s_pop, n_load - s_load);
    end
    checks++;
    if (n_stx - s_stx !== 16) begin failures++; $display("FAIL rd_shift_tx: got %0d expected 16", n_stx - s_stx); end
    checks++;
    if (fsm_state !== ST_WAIT_STOP) begin failures++; $display("FAIL rd_nack_state: got %0d expected %0d", fsm_state, ST_WAIT_STOP); end
    do_stop();
    checks++;
    if (n_done - s_done !== 1) begin failures++; $display("FAIL rd_complete: got %0d expected 1", n_done - s_done); end
  endtask

  task automatic test_rx_stretch();
    snap();
    do_start();
    send_addr({OWN_ADDR, 1'b0});
    send_bit(1'b0);
    rx_fifo_full = 1'b1; stretch_enabled = 1'b1;
    send_bits(8'h3C, 7);
    scl_rise(1'b0);
    checks++;
    if (fsm_state !== ST_RX_SAVE || scl_hold !== 1'b0) begin
      failures++; $display("FAIL st_before_fall: state %0d hold %0d expected %0d/0", fsm_state, scl_hold, ST_RX_SAVE);
    end
    scl_fall();
    checks++;
    if (scl_hold !== 1'b1) begin failures++; $display("FAIL st_hold: got %0d expected 1", scl_hold); end
    tick(20);
    checks++;
    if (scl_hold !== 1'b1 || n_push - s_push !== 0) begin
      failures++; $display("FAIL st_held: hold %0d push %0d expected 1/0", scl_hold, n_push - s_push);
    end
    @(negedge clk); rx_fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_fifo_enable !== 1'b1 || scl_hold !== 1'b0 || sda_mode !== 2'd1) begin
      failures++; $display("FAIL st_release: push %0d hold %0d sda_mode %0d expected 1/0/1", rx_fifo_enable, scl_hold, sda_mode);
    end
    send_bit(1'b0);
    checks++;
    if (fsm_state !== ST_RX_BYTE || n_push - s_push !== 1) begin
      failures++; $display("FAIL st_after_ack: state %0d push %0d expected %0d/1", fsm_state, n_push - s_push, ST_RX_BYTE);
    end
    do_stop();
  endtask

  task automatic test_rx_nack();
    snap();
    rx_fifo_full = 1'b1; stretch_enabled = 1'b0;
    do_start();
    send_addr({OWN_ADDR, 1'b0});
    send_bit(1'b0);
    send_bits(8'h5A, 7);
    scl_rise(1'b0);
    checks++;
    if (n_nack - s_nack !== 1 || fsm_state !== ST_ACK_WAIT) begin
      failures++; $display("FAIL nk_sent: nack %0d state %0d expected 1/%0d", n_nack - s_nack, fsm_state, ST_ACK_WAIT);
    end
    scl_fall();
    send_bit(1'b1);
    checks++;
    if (fsm_state !== ST_WAIT_STOP) begin failures++; $display("FAIL nk_state: got %0d expected %0d", fsm_state, ST_WAIT_STOP); end
    checks++;
    if (n_ack - s_ack !== BIT_CYCLES || n_push - s_push !== 0) begin
      failures++; $display("FAIL nk_ack_slot: ack %0d push %0d expected %0d/0", n_ack - s_ack, n_push - s_push, BIT_CYCLES);
    end
    do_stop();
    rx_fifo_full = 1'b0; stretch_enabled = 1'b1;
  endtask

  task automatic test_tx_empty();
    snap();
    tx_fifo_empty = 1'b1; stretch_enabled = 1'b1;
    do_start();
    send_addr({OWN_ADDR, 1'b1});
    send_bit(1'b0);
    checks++;
    if (fsm_state !== ST_TX_STRETCH || scl_hold !== 1'b1) begin
      failures++; $display("FAIL te_stretch: state %0d hold %0d expected %0d/1", fsm_state, scl_hold, ST_TX_STRETCH);
    end
    tick(5);
    @(negedge clk); tx_fifo_empty = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_state !== ST_TX_LOAD || shift_load !== 1'b1 || tx_fifo_enable !== 1'b1 || scl_hold !== 1'b1 || sda_mode !== 2'd2) begin
      failures++; $display("FAIL te_load: state %0d load %0d pop %0d hold %0d sda %0d expected %0d/1/1/1/2",
                           fsm_state, shift_load, tx_fifo_enable, scl_hold, sda_mode, ST_TX_LOAD);
    end
    do_stop();
    snap();
    tx_fifo_empty = 1'b1; stretch_enabled = 1'b0;
    do_start();
    send_addr({OWN_ADDR, 1'b1});
    send_bit(1'b0);
    checks++;
    if (fsm_state !== ST_TX_BYTE || n_load - s_load !== 1 || n_pop - s_pop !== 0) begin
      failures++; $display("FAIL te_no_pop: state %0d load %0d pop %0d expected %0d/1/0", fsm_state, n_load - s_load, n_pop - s_pop, ST_TX_BYTE);
    end
    do_stop();
    tx_fifo_empty = 1'b0; stretch_enabled = 1'b1;
  endtask

  task automatic test_repeated_start();
    snap();
    do_start();
    send_addr({OWN_ADDR, 1'b0});
    send_bit(1'b0);
    send_bits(8'hF0, 3);
    do_start();
    checks++;
    if (fsm_state !== ST_ADDR_RX || busy !== 1'b1 || n_done - s_done !== 0) begin
      failures++; $display("FAIL rs_restart: state %0d busy %0d done %0d expected %0d/1/0", fsm_state, busy, n_done - s_done, ST_ADDR_RX);
    end
    send_addr({OWN_ADDR, 1'b1});
    send_bit(1'b0);
    checks++;
    if (fsm_state !== ST_TX_BYTE || sda_mode !== 2'd2 || n_hit - s_hit !== 2) begin
      failures++; $display("FAIL rs_read_dir: state %0d sda %0d hit %0d expected %0d/2/2", fsm_state, sda_mode, n_hit - s_hit, ST_TX_BYTE);
    end
    do_stop();
    checks++;
    if (n_done - s_done !== 1) begin failures++; $display("FAIL rs_complete: got %0d expected 1", n_done - s_done); end
  endtask

  task automatic test_async_reset();
    snap();
    do_start();
    send_addr({OWN_ADDR, 1'b1});
    send_bit(1'b0);
    send_bits(8'h00, 3);
    checks++;
    if (sda_mode !== 2'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL ar_pre: sda %0d busy %0d expected 2/1", sda_mode, busy);
    end
    @(negedge clk); n_rst = 1'b0;
    #1;
    checks++;
    if (outs !== 12'd0 || fsm_state !== ST_IDLE) begin
      failures++; $display("FAIL ar_async: outs %h state %0d expected 000/0", outs, fsm_state);
    end
    tick(2); n_rst = 1'b1;
    tick(3);
    checks++;
    if (fsm_state !== ST_IDLE || n_done - s_done !== 0) begin
      failures++; $display("FAIL ar_release: state %0d done %0d expected 0/0", fsm_state, n_done - s_done);
    end
  endtask

  task automatic test_enable();
    snap();
    do_start();
    send_addr({OWN_ADDR, 1'b0});
    send_bit(1'b0);
    send_bits(8'hC0, 2);
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_state !== ST_IDLE || outs !== 12'd0) begin
      failures++; $display("FAIL en_off: state %0d outs %h expected 0/000", fsm_state, outs);
    end
    enable = 1'b1;
    do_stop();
    checks++;
    if (n_done - s_done !== 0) begin failures++; $display("FAIL en_no_complete: got %0d expected 0", n_done - s_done); end
  endtask

  task automatic test_back_to_back();
    snap();
    do_start();
    send_addr({OWN_ADDR, 1'b0});
    send_bit(1'b0);
    send_bits(8'h12, 8);
    send_bit(1'b0);
    send_bits(8'h34, 8);
    send_bit(1'b0);
    do_stop();
    checks++;
    if (n_push - s_push !== 2 || n_srx - s_srx !== 24) begin
      failures++; $display("FAIL b2b_bytes: push %0d shift %0d expected 2/24", n_push - s_push, n_srx - s_srx);
    end
    checks++;
    if (n_ack - s_ack !== 3 * BIT_CYCLES || n_done - s_done !== 1) begin
      failures++; $display("FAIL b2b_ack_done: ack %0d done %0d expected %0d/1", n_ack - s_ack, n_done - s_done, 3 * BIT_CYCLES);
    end
  endtask

  // ---- sequence and report ----
  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_rx_stretch();
    test_rx_nack();
    test_tx_empty();
    test_repeated_start();
    test_async_reset();
    test_enable();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
